csa_accum_sched: RTL



---
 rtl/csa_acc_pkg.sv | 24 ++
 rtl/CarrySaveAdder.sv | 22 ++
 rtl/csa_accum_sched_chunk_adder.sv | 22 ++
 rtl/csa_accum_sched.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/csa_acc_pkg.sv
// ---------------------------------------------------------------------------
// csa_acc_pkg
// Shared types and helpers for the carry-save accumulator sequencer.
//   state_t      : sequencer states
//   nchunk()     : number of CHUNK-bit slices needed to cover an (n+1)-bit value
//   CHUNK_IDX_W  : width of the resolve-phase chunk index register
// ---------------------------------------------------------------------------
package csa_acc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Chunk index must be able to count one step past the last chunk.
    localparam int unsigned CHUNK_IDX_W = 8;

    function automatic int nchunk(input int n, input int chunk);
        return (n + 1 + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/CarrySaveAdder.sv
// ---------------------------------------------------------------------------
// CarrySaveAdder
// Shared 3:2 compressor over (N+1)-bit vectors. Produces the bitwise sum and
// the unshifted majority vector; the caller aligns the majority as carries.
//   a, b, c : addends
//   sum     : a ^ b ^ c
//   maj     : majority(a, b, c), bit i has weight 2^(i+1)
// ---------------------------------------------------------------------------
module CarrySaveAdder #(
    parameter int N = 64
) (
    input  logic [N:0] a,
    input  logic [N:0] b,
    input  logic [N:0] c,
    output logic [N:0] sum,
    output logic [N:0] maj
);

    assign sum = a ^ b ^ c;
    assign maj = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_accum_sched_chunk_adder.sv
// ---------------------------------------------------------------------------
// csa_chunk_adder
// Narrow combinational adder used to resolve the redundant pair one slice
// at a time.
//   a, b : CHUNK-bit slices of sum and carry vectors
//   cin  : carry from the previous slice
//   sum  : a + b + cin (low CHUNK bits)
//   cout : carry out of the slice
// ---------------------------------------------------------------------------
module csa_chunk_adder #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = (CHUNK+1)'(a) + (CHUNK+1)'(b) + (CHUNK+1)'(cin);

endmodule

// File: rtl/csa_accum_sched.sv
// ---------------------------------------------------------------------------
// csa_accum_sched
// Streaming multi-operand accumulator. Operand beats are folded into a
// redundant (s, c) pair through a 3:2 compressor at one per cycle; after the
// last beat the pair is resolved to binary CHUNK bits per cycle and the
// (N+1)-bit result is offered downstream on a valid/ready handshake.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   in_valid/in_ready           : operand handshake
//   in_data, in_last            : operand and end-of-packet marker
//   out_valid/out_ready         : result handshake
//   out_sum                     : packet sum mod 2^(N+1)
//   out_ovf                     : true sum >= 2^(N+1) (only with CSA_ACC_OVF_EN)
//   busy                        : sequencer not idle
// Optional feature: define CSA_ACC_OVF_EN to add the exact overflow flag.
// ---------------------------------------------------------------------------
module csa_accum_sched
    import csa_acc_pkg::*;
#(
    parameter int N     = 64,
    parameter int CHUNK = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   out_sum,
`ifdef CSA_ACC_OVF_EN
    output logic         out_ovf,
`endif
    output logic         busy
);

    localparam int NCHUNK = nchunk(N, CHUNK);
    localparam int W      = NCHUNK * CHUNK;

    state_t                 state, state_nxt;
    logic [N:0]             s, c, res;
    logic [N:0]             din, csa_sum, csa_maj;
    logic [W-1:0]           s_pad, c_pad;
    logic [CHUNK_IDX_W-1:0] k;
    logic                   cy;
    logic                   beat;
    logic                   resolve_run, last_chunk;
    int                     chunk_idx;
    logic [CHUNK-1:0]       add_a, add_b, add_sum;
    logic                   add_cout;
    logic                   top_carry;
    logic                   unused_maj_top;

    assign din  = (N+1)'(in_data);
    assign beat = in_valid & in_ready;

    CarrySaveAdder #(.N(N)) u_csa (
        .a   (s),
        .b   (c),
        .c   (din),
        .sum (csa_sum),
        .maj (csa_maj)
    );

    // Zero-pad so the top slice reads zeros above bit N.
    assign s_pad = W'(s);
    assign c_pad = W'(c);

    assign resolve_run = int'(k) < NCHUNK;
    assign last_chunk  = int'(k) == NCHUNK - 1;
    assign chunk_idx   = resolve_run ? int'(k) : 0;
    assign add_a       = s_pad[chunk_idx*CHUNK +: CHUNK];
    assign add_b       = c_pad[chunk_idx*CHUNK +: CHUNK];

    csa_chunk_adder #(.CHUNK(CHUNK)) u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (cy),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Weight 2^(N+1) out of the top slice: a padded sum bit, or the slice
    // carry-out when N+1 is an exact multiple of CHUNK.
    localparam int TOP_BIT = N + 1 - (NCHUNK - 1) * CHUNK;
    generate
        if (TOP_BIT == CHUNK) begin : g_top_cout
            assign top_carry = add_cout;
        end else begin : g_top_pad
            assign top_carry = add_sum[TOP_BIT];
        end
    endgenerate

    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE, ACCUM: begin
                in_ready = 1'b1;
                if (beat) state_nxt = in_last ? RESOLVE : ACCUM;
            end
            RESOLVE: begin
                // One settle step after the last slice registers the result
                // before it is offered downstream.
                if (!resolve_run) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy    = (state != IDLE);
    assign out_sum = res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s   <= '0;
            c   <= '0;
            res <= '0;
            cy  <= 1'b0;
            k   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (beat) begin
                        s  <= din;
                        c  <= '0;
                        k  <= '0;
                        cy <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        s <= csa_sum;
                        c <= {csa_maj[N-1:0], 1'b0};
                    end
                end
                RESOLVE: begin
                    if (resolve_run) begin
                        for (int b = 0; b <= N; b++) begin
                            if (b / CHUNK == chunk_idx) res[b] <= add_sum[b % CHUNK];
                        end
                        cy <= add_cout;
                        k  <= k + 1'b1;
                    end else begin
                        k  <= '0;
                        cy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CSA_ACC_OVF_EN
    logic ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else begin
            if (state == IDLE && beat)
                ovf <= 1'b0;
            else if (state == ACCUM && beat && csa_maj[N])
                ovf <= 1'b1;
            else if (state == RESOLVE && last_chunk && top_carry)
                ovf <= 1'b1;
        end
    end

    assign out_ovf        = ovf;
    assign unused_maj_top = 1'b0;
`else
    // Without the flag the discarded weight-2^(N+1) bits are simply dropped.
    assign unused_maj_top = csa_maj[N] ^ top_carry ^ last_chunk;
`endif

endmodule
